// File: rtl/tohost_mailbox_if.sv
// CPU-side request/response bus of the tohost/fromhost mailbox.
// master = CPU (or bench) side, slave = mailbox side.
interface tohost_mailbox_if #(
   parameter int ADDR_W = 4
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [63:0]       req_wdata;
   logic [7:0]        req_wstrb;
   logic              resp_valid;
   logic              resp_ready;
   logic [63:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/tohost_mailbox.sv
// tohost/fromhost mailbox: latches CPU tohost stores, exposes exit/syscall state to the host,
// takes fromhost replies and flags a host that never answers. Trace output: define TOHOST_TRACE_EN.
//
// state  | meaning
// -------+------------------------------------------------
// S_IDLE | no tohost request outstanding
// S_PEND | syscall pointer in tohost, waiting for host_we
// S_DONE | exit written (tohost bit0 set), terminal until reset
module tohost_mailbox #(
   parameter int          ADDR_W         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                clock,
   input  logic                reset,
   tohost_mailbox_if.slave     bus,
   output logic [63:0]         tohost,
   output logic                tohost_valid,
   output logic [62:0]         exit_code,
   output logic                done,
   input  logic                host_we,
   input  logic [63:0]         host_wdata,
   output logic                timeout,
   output logic                timeout_sticky
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} state_t;

   localparam logic [63:0]       TO_LAST    = (TIMEOUT_CYCLES == 0) ? 64'd0 : 64'(TIMEOUT_CYCLES) - 64'd1;
   localparam logic [63:0]       CNT_SAT    = (TIMEOUT_CYCLES == 0) ? '1 : 64'(TIMEOUT_CYCLES);
   localparam logic [ADDR_W-1:0] A_TOHOST   = '0;
   localparam logic [ADDR_W-1:0] A_FROMHOST = ADDR_W'(8);

   state_t      state_q, state_d;
   logic [63:0] tohost_q, tohost_d;
   logic [63:0] fromhost_q, fromhost_d;
   logic [63:0] cnt_q, cnt_d;
   logic        sticky_q, sticky_d;
   logic        resp_valid_q, resp_valid_d;
   logic [63:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic        is_tohost, is_fromhost, accept;
   logic [63:0] wmask, cur_val, merged;

   assign is_tohost   = (bus.req_addr == A_TOHOST);
   assign is_fromhost = (bus.req_addr == A_FROMHOST);

   // A second tohost store waits until the host has serviced the pending syscall.
   assign bus.req_ready = (!resp_valid_q || bus.resp_ready) &&
                          !(bus.req_write && is_tohost && state_q == S_PEND);
   assign accept        = bus.req_valid && bus.req_ready;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         wmask[8*i +: 8] = {8{bus.req_wstrb[i]}};
      end
   end

   assign cur_val = is_tohost ? tohost_q : fromhost_q;
   assign merged  = (cur_val & ~wmask) | (bus.req_wdata & wmask);

   assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == S_PEND) && (cnt_q == TO_LAST);

   always_comb begin
      state_d      = state_q;
      tohost_d     = tohost_q;
      fromhost_d   = fromhost_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      sticky_d     = sticky_q | timeout;

      if (bus.resp_ready) begin
         resp_valid_d = 1'b0;
         resp_rdata_d = '0;
         resp_err_d   = 1'b0;
      end

      if (accept) begin
         resp_valid_d = 1'b1;
         resp_err_d   = !(is_tohost || is_fromhost);
         resp_rdata_d = (!bus.req_write && (is_tohost || is_fromhost)) ? cur_val : '0;
         if (bus.req_write && is_tohost && state_q == S_IDLE) begin
            tohost_d = merged;
            if (merged[0])          state_d = S_DONE;
            else if (merged != '0) state_d = S_PEND;
         end
         if (bus.req_write && is_fromhost) fromhost_d = merged;
      end

      // Host reply overrides a same-cycle CPU fromhost store.
      if (host_we) begin
         fromhost_d = host_wdata;
         if (state_q == S_PEND) begin
            tohost_d = '0;
            state_d  = S_IDLE;
         end
      end

      if (state_q == S_PEND && state_d == S_PEND) cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 64'd1;
      else                                        cnt_d = '0;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         tohost_q     <= '0;
         fromhost_q   <= '0;
         cnt_q        <= '0;
         sticky_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         tohost_q     <= tohost_d;
         fromhost_q   <= fromhost_d;
         cnt_q        <= cnt_d;
         sticky_q     <= sticky_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign tohost         = tohost_q;
   assign tohost_valid   = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign exit_code      = tohost_q[63:1];
   assign timeout_sticky = sticky_q;

`ifdef TOHOST_TRACE_EN
   logic [63:0] trace_cyc_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         trace_cyc_q <= '0;
      end else begin
         trace_cyc_q <= trace_cyc_q + 64'd1;
         if (accept && bus.req_write && is_tohost)
            $display("[%0d] tohost store value=%h state=%s", trace_cyc_q, merged, state_d.name());
         if (host_we)
            $display("[%0d] fromhost=%h", trace_cyc_q, host_wdata);
         if (state_d == S_DONE && state_q != S_DONE)
            $display("EXIT code=%0d", tohost_d[63:1]);
      end
   end
`endif

endmodule

// File: tb/tb_tohost_mailbox.sv
// Directed bench for tohost_mailbox: exit, syscall stall/reply, timeout, merge, back-pressure, reset.
module tb_tohost_mailbox;

   logic        clock;
   logic        reset;
   logic [63:0] tohost;
   logic        tohost_valid;
   logic [62:0] exit_code;
   logic        done;
   logic        host_we;
   logic [63:0] host_wdata;
   logic        timeout;
   logic        timeout_sticky;

   int n_checks = 0;
   int n_pass   = 0;

   tohost_mailbox_if #(.ADDR_W(4)) bus ();

   tohost_mailbox #(.ADDR_W(4), .TIMEOUT_CYCLES(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .tohost         (tohost),
      .tohost_valid   (tohost_valid),
      .exit_code      (exit_code),
      .done           (done),
      .host_we        (host_we),
      .host_wdata     (host_wdata),
      .timeout        (timeout),
      .timeout_sticky (timeout_sticky)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting posedge.
   task automatic do_req(input logic w, input logic [3:0] a, input logic [63:0] d,
                         input logic [7:0] s, input string tag);
      logic ok;
      ok            = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (ok) @(negedge clock);
      bus.req_valid = 1'b0;
      chk(tag, {63'd0, ok}, 64'd1);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   int pulses;
   int first_idx;

   initial begin
      reset          = 1'b0;
      host_we        = 1'b0;
      host_wdata     = '0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_wstrb  = '0;
      bus.resp_ready = 1'b1;
      repeat (2) @(negedge clock);

      // Reset state
      chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
      chk("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
      chk("rst_tohost", tohost, 64'd0);
      chk("rst_tohost_valid", {63'd0, tohost_valid}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_timeout", {63'd0, timeout}, 64'd0);
      chk("rst_sticky", {63'd0, timeout_sticky}, 64'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("idle_req_ready", {63'd0, bus.req_ready}, 64'd1);

      // Exit with code 0; later tohost stores are discarded
      do_req(1'b1, 4'h0, 64'h1, 8'hFF, "acc_exit0");
      chk("exit0_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
      chk("exit0_resp_rdata", bus.resp_rdata, 64'd0);
      chk("exit0_done", {63'd0, done}, 64'd1);
      chk("exit0_tohost_valid", {63'd0, tohost_valid}, 64'd1);
      chk("exit0_exit_code", {1'b0, exit_code}, 64'd0);
      do_req(1'b1, 4'h0, 64'h55, 8'hFF, "acc_done_store");
      chk("done_store_resp", {63'd0, bus.resp_valid}, 64'd1);
      chk("done_store_tohost", tohost, 64'h1);
      pulse_reset();
      chk("post_rst_done", {63'd0, done}, 64'd0);

      // Exit code 21
      do_req(1'b1, 4'h0, 64'h2B, 8'hFF, "acc_exit21");
      chk("exit21_done", {63'd0, done}, 64'd1);
      chk("exit21_code", {1'b0, exit_code}, 64'd21);
      pulse_reset();

      // Syscall: second store stalls, host reply releases it
      do_req(1'b1, 4'h0, 64'h8000_1000, 8'hFF, "acc_syscall");
      chk("sys_tohost_valid", {63'd0, tohost_valid}, 64'd1);
      chk("sys_done", {63'd0, done}, 64'd0);
      chk("sys_tohost", tohost, 64'h8000_1000);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 4'h0;
      bus.req_wdata = 64'h3;
      bus.req_wstrb = 8'hFF;
      #1;
      chk("stall_ready_0", {63'd0, bus.req_ready}, 64'd0);
      @(negedge clock);
      chk("stall_ready_1", {63'd0, bus.req_ready}, 64'd0);
      host_we    = 1'b1;
      host_wdata = 64'h1;
      #1;
      chk("stall_ready_hostwe", {63'd0, bus.req_ready}, 64'd0);
      @(negedge clock);
      host_we = 1'b0;
      chk("reply_tohost", tohost, 64'd0);
      chk("reply_tohost_valid", {63'd0, tohost_valid}, 64'd0);
      chk("reply_ready", {63'd0, bus.req_ready}, 64'd1);
      @(negedge clock);
      bus.req_valid = 1'b0;
      chk("released_resp", {63'd0, bus.resp_valid}, 64'd1);
      chk("released_done", {63'd0, done}, 64'd1);
      chk("released_code", {1'b0, exit_code}, 64'd1);
      do_req(1'b0, 4'h8, 64'd0, 8'h00, "acc_ld_fromhost");
      chk("fromhost_after_reply", bus.resp_rdata, 64'h1);
      pulse_reset();

      // Timeout: host never replies
      do_req(1'b1, 4'h0, 64'h80, 8'hFF, "acc_to_syscall");
      pulses    = 0;
      first_idx = -1;
      for (int i = 0; i < 24; i++) begin
         if (timeout === 1'b1) begin
            pulses++;
            if (first_idx < 0) first_idx = i;
         end
         @(negedge clock);
      end
      chk("timeout_pulses", 64'(pulses), 64'd1);
      chk("timeout_cycle", 64'(first_idx), 64'd15);
      chk("timeout_sticky_set", {63'd0, timeout_sticky}, 64'd1);
      host_we    = 1'b1;
      host_wdata = 64'hDEAD;
      @(negedge clock);
      host_we = 1'b0;
      chk("to_reply_idle", {63'd0, tohost_valid}, 64'd0);
      chk("to_sticky_kept", {63'd0, timeout_sticky}, 64'd1);
      chk("to_no_refire", {63'd0, timeout}, 64'd0);
      pulse_reset();
      chk("sticky_cleared", {63'd0, timeout_sticky}, 64'd0);

      // Byte merge, unmapped, zero-strobe
      do_req(1'b1, 4'h8, 64'hAABB, 8'h01, "acc_fh_byte");
      do_req(1'b0, 4'h8, 64'd0, 8'h00, "acc_ld_fh1");
      chk("merge_byte0", bus.resp_rdata, 64'hBB);
      do_req(1'b1, 4'h8, 64'h1111_2222_3333_4444, 8'hF0, "acc_fh_hi");
      do_req(1'b0, 4'h8, 64'd0, 8'h00, "acc_ld_fh2");
      chk("merge_hi", bus.resp_rdata, 64'h1111_2222_0000_00BB);
      chk("mapped_err", {63'd0, bus.resp_err}, 64'd0);
      do_req(1'b0, 4'h4, 64'd0, 8'h00, "acc_ld_unmapped");
      chk("unmapped_err", {63'd0, bus.resp_err}, 64'd1);
      chk("unmapped_rdata", bus.resp_rdata, 64'd0);
      do_req(1'b1, 4'h0, 64'h7, 8'h00, "acc_zero_strb");
      chk("zero_strb_tohost", tohost, 64'd0);
      chk("zero_strb_idle", {63'd0, tohost_valid}, 64'd0);

      // Response back-pressure
      @(negedge clock);
      bus.resp_ready = 1'b0;
      do_req(1'b0, 4'h8, 64'd0, 8'h00, "acc_ld_hold");
      for (int i = 0; i < 3; i++) begin
         chk("hold_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
         chk("hold_req_ready", {63'd0, bus.req_ready}, 64'd0);
         chk("hold_rdata", bus.resp_rdata, 64'h1111_2222_0000_00BB);
         @(negedge clock);
      end
      bus.resp_ready = 1'b1;
      @(negedge clock);
      chk("hold_released", {63'd0, bus.resp_valid}, 64'd0);

      // Reset in PEND with a held response
      bus.resp_ready = 1'b0;
      do_req(1'b1, 4'h0, 64'h40, 8'hFF, "acc_pend_hold");
      chk("pend_before_rst", {63'd0, tohost_valid}, 64'd1);
      reset = 1'b0;
      @(negedge clock);
      reset          = 1'b1;
      bus.resp_ready = 1'b1;
      chk("mid_rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("mid_rst_tohost", tohost, 64'd0);
      chk("mid_rst_tohost_valid", {63'd0, tohost_valid}, 64'd0);
      chk("mid_rst_fromhost", {63'd0, done}, 64'd0);
      do_req(1'b1, 4'h0, 64'h5, 8'hFF, "acc_after_rst");
      chk("after_rst_done", {63'd0, done}, 64'd1);
      chk("after_rst_code", {1'b0, exit_code}, 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
